// File: rtl/vip_cfg_seq.sv
// vip_cfg_seq - Avalon-MM master that programs the video IP chain (scaler,
// mixer, clocked video output). It runs after power-up and again whenever
// the aspect ratio, output mode or source size changes.
//
// Optional build macro: VIP_INTEGER_SCALE_EN. When it is defined, an extra
// stage snaps the fitted video size to an integer multiple of the source size.
//
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   ARX, ARY           aspect numerator / denominator
//   vmode[95:0]        WIDTH,HEIGHT,HFP,HS,HBP,VFP,VS,VBP (12 bits each, LSB first)
//   src_w, src_h       source active size
//   address, write,    Avalon-MM master write port; a transfer is held
//   writedata,         until waitrequest is low
//   waitrequest
//   busy               sequence in progress
//   done               last sequence completed with the current inputs
module vip_cfg_seq #(
   parameter int ADDR_W      = 9,
   parameter int TIMEOUT     = 1000000,
   parameter int BASE_SCALER = 'h000,
   parameter int BASE_MIXER  = 'h080,
   parameter int BASE_CVO    = 'h100
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        ARX,
   input  logic [7:0]        ARY,
   input  logic [95:0]       vmode,
   input  logic [11:0]       src_w,
   input  logic [11:0]       src_h,
   output logic [ADDR_W-1:0] address,
   output logic              write,
   output logic [31:0]       writedata,
   input  logic              waitrequest,
   output logic              busy,
   output logic              done
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_DEB, S_CALC_W, S_CALC_H, S_FIT,
`ifdef VIP_INTEGER_SCALE_EN
      S_INT_W, S_INT_H,
`endif
      S_GAP, S_WRITE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_arx, r_ary;
   logic [95:0]   r_vmode;
   logic [11:0]   r_srcw, r_srch;
   logic [23:0]   r_dvd;            // dividend shifts out, quotient shifts in
   logic [11:0]   r_dvs;
   logic [11:0]   r_rem;
   logic [4:0]    r_bit;
   logic [23:0]   r_wcalc, r_hcalc;
   logic [11:0]   r_videow, r_videoh;
   logic [4:0]    r_idx;

   logic [11:0] w_wid, w_hgt, w_hfp, w_hs, w_hbp, w_vfp, w_vs, w_vbp;
   assign {w_vbp, w_vs, w_vfp, w_hbp, w_hs, w_hfp, w_hgt, w_wid} = r_vmode;

   logic w_chg, w_restart;
   assign w_chg = (ARX != r_arx) || (ARY != r_ary) || (vmode != r_vmode) ||
                  (src_w != r_srcw) || (src_h != r_srch);
   // A stalled transfer must finish its accept before a restart takes over.
   assign w_restart = w_chg && ((r_state != S_WRITE) || !waitrequest);

   // Restoring divider step: one quotient bit per cycle, MSB first.
   logic [12:0] w_trial;
   logic        w_ge, w_last;
   logic [23:0] w_q;
   assign w_trial = {r_rem, r_dvd[23]};
   assign w_ge    = w_trial >= {1'b0, r_dvs};
   assign w_q     = {r_dvd[22:0], w_ge};
   assign w_last  = (r_bit == 5'd23);

   logic [11:0] w_fitw, w_fith, w_posx, w_posy;
   assign w_fitw = (r_wcalc > 24'(w_wid)) ? w_wid : r_wcalc[11:0];
   assign w_fith = (r_hcalc > 24'(w_hgt)) ? w_hgt : r_hcalc[11:0];
   assign w_posx = (w_wid - r_videow) >> 1;
   assign w_posy = (w_hgt - r_videoh) >> 1;

   logic [ADDR_W-1:0] w_tab_addr;
   logic [31:0]       w_tab_data;
   always_comb begin
      w_tab_addr = '0;
      w_tab_data = '0;
      case (r_idx)
         5'd0:  begin w_tab_addr = ADDR_W'(BASE_SCALER + 'h3);  w_tab_data = 32'(r_videow); end
         5'd1:  begin w_tab_addr = ADDR_W'(BASE_SCALER + 'h4);  w_tab_data = 32'(r_videoh); end
         5'd2:  begin w_tab_addr = ADDR_W'(BASE_SCALER);        w_tab_data = 32'd1; end
         5'd3:  begin w_tab_addr = ADDR_W'(BASE_MIXER + 'h3);   w_tab_data = 32'(w_wid); end
         5'd4:  begin w_tab_addr = ADDR_W'(BASE_MIXER + 'h4);   w_tab_data = 32'(w_hgt); end
         5'd5:  begin w_tab_addr = ADDR_W'(BASE_MIXER + 'h8);   w_tab_data = 32'(w_posx); end
         5'd6:  begin w_tab_addr = ADDR_W'(BASE_MIXER + 'h9);   w_tab_data = 32'(w_posy); end
         5'd7:  begin w_tab_addr = ADDR_W'(BASE_MIXER + 'hA);   w_tab_data = 32'd1; end
         5'd8:  begin w_tab_addr = ADDR_W'(BASE_MIXER);         w_tab_data = 32'd1; end
         5'd9:  begin w_tab_addr = ADDR_W'(BASE_CVO + 'h4);     w_tab_data = 32'd0; end
         5'd10: begin w_tab_addr = ADDR_W'(BASE_CVO + 'h5);     w_tab_data = 32'd0; end
         5'd11: begin w_tab_addr = ADDR_W'(BASE_CVO + 'h6);     w_tab_data = 32'(w_wid); end
         5'd12: begin w_tab_addr = ADDR_W'(BASE_CVO + 'h7);     w_tab_data = 32'(w_hgt); end
         5'd13: begin w_tab_addr = ADDR_W'(BASE_CVO + 'h9);     w_tab_data = 32'(w_hfp); end
         5'd14: begin w_tab_addr = ADDR_W'(BASE_CVO + 'hA);     w_tab_data = 32'(w_hs); end
         5'd15: begin w_tab_addr = ADDR_W'(BASE_CVO + 'hB);     w_tab_data = 32'(w_hfp) + 32'(w_hs) + 32'(w_hbp); end
         5'd16: begin w_tab_addr = ADDR_W'(BASE_CVO + 'hC);     w_tab_data = 32'(w_vfp); end
         5'd17: begin w_tab_addr = ADDR_W'(BASE_CVO + 'hD);     w_tab_data = 32'(w_vs); end
         5'd18: begin w_tab_addr = ADDR_W'(BASE_CVO + 'hE);     w_tab_data = 32'(w_vfp) + 32'(w_vs) + 32'(w_vbp); end
         5'd19: begin w_tab_addr = ADDR_W'(BASE_CVO + 'h1E);    w_tab_data = 32'd1; end
         5'd20: begin w_tab_addr = ADDR_W'(BASE_CVO);           w_tab_data = 32'd1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_DEB;
         r_cnt     <= '0;
         r_arx     <= '0;
         r_ary     <= '0;
         r_vmode   <= '0;
         r_srcw    <= '0;
         r_srch    <= '0;
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_rem     <= '0;
         r_bit     <= '0;
         r_wcalc   <= '0;
         r_hcalc   <= '0;
         r_videow  <= '0;
         r_videoh  <= '0;
         r_idx     <= '0;
         address   <= '0;
         write     <= 1'b0;
         writedata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (w_restart) begin
         r_arx   <= ARX;
         r_ary   <= ARY;
         r_vmode <= vmode;
         r_srcw  <= src_w;
         r_srch  <= src_h;
         r_cnt   <= '0;
         busy    <= 1'b1;
         done    <= 1'b0;
         write   <= 1'b0;
         r_state <= S_DEB;
      end else begin
         case (r_state)
            S_DEB: begin
               // done marks the saturated idle state: nothing to do until a change.
               if (!done) begin
                  if (r_cnt == CNT_END) begin
                     busy <= 1'b1;
                     if (r_arx == 8'd0 || r_ary == 8'd0) begin
                        r_wcalc <= 24'(w_wid);
                        r_hcalc <= 24'(w_hgt);
                        r_state <= S_FIT;
                     end else begin
                        r_dvd   <= 24'(w_hgt) * 24'(r_arx);
                        r_dvs   <= {4'd0, r_ary};
                        r_rem   <= '0;
                        r_bit   <= '0;
                        r_state <= S_CALC_W;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_CALC_W: begin
               r_dvd <= w_q;
               r_rem <= w_ge ? 12'(w_trial - {1'b0, r_dvs}) : w_trial[11:0];
               r_bit <= r_bit + 1'b1;
               if (w_last) begin
                  r_wcalc <= w_q;
                  r_dvd   <= 24'(w_wid) * 24'(r_ary);
                  r_dvs   <= {4'd0, r_arx};
                  r_rem   <= '0;
                  r_bit   <= '0;
                  r_state <= S_CALC_H;
               end
            end
            S_CALC_H: begin
               r_dvd <= w_q;
               r_rem <= w_ge ? 12'(w_trial - {1'b0, r_dvs}) : w_trial[11:0];
               r_bit <= r_bit + 1'b1;
               if (w_last) begin
                  r_hcalc <= w_q;
                  r_state <= S_FIT;
               end
            end
            S_FIT: begin
               r_videow <= w_fitw;
               r_videoh <= w_fith;
               r_idx    <= '0;
`ifdef VIP_INTEGER_SCALE_EN
               r_dvd    <= 24'(w_fitw);
               r_dvs    <= r_srcw;
               r_rem    <= '0;
               r_bit    <= '0;
               r_state  <= S_INT_W;
`else
               r_state  <= S_GAP;
`endif
            end
`ifdef VIP_INTEGER_SCALE_EN
            // Both stages always run their full 24 cycles; the guard only
            // decides whether the snapped size is kept.
            S_INT_W: begin
               r_dvd <= w_q;
               r_rem <= w_ge ? 12'(w_trial - {1'b0, r_dvs}) : w_trial[11:0];
               r_bit <= r_bit + 1'b1;
               if (w_last) begin
                  if (r_srcw != 12'd0 && r_videow >= r_srcw)
                     r_videow <= w_q[11:0] * r_srcw;
                  r_dvd   <= 24'(r_videoh);
                  r_dvs   <= r_srch;
                  r_rem   <= '0;
                  r_bit   <= '0;
                  r_state <= S_INT_H;
               end
            end
            S_INT_H: begin
               r_dvd <= w_q;
               r_rem <= w_ge ? 12'(w_trial - {1'b0, r_dvs}) : w_trial[11:0];
               r_bit <= r_bit + 1'b1;
               if (w_last) begin
                  if (r_srch != 12'd0 && r_videoh >= r_srch)
                     r_videoh <= w_q[11:0] * r_srch;
                  r_state <= S_GAP;
               end
            end
`endif
            // The write port only changes here, while write is low.
            S_GAP: begin
               address   <= w_tab_addr;
               writedata <= w_tab_data;
               write     <= 1'b1;
               r_state   <= S_WRITE;
            end
            S_WRITE: begin
               if (!waitrequest) begin
                  write <= 1'b0;
                  if (r_idx == 5'd20) begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     r_cnt   <= CNT_END;
                     r_state <= S_DEB;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= S_GAP;
                  end
               end
            end
            default: r_state <= S_DEB;
         endcase
      end
   end

endmodule

// File: doc/vip_cfg_seq.md
Name: vip_cfg_seq

Overview:
- Parametrised Avalon-MM master that programs the video IP chain (scaler, mixer, clocked video output) after power-up and on every change of aspect ratio, output mode or source size.
- Successor to the fixed-mode configurator:
  - output timing is runtime-selectable through a packed mode bus;
  - register bases are parametrised;
  - the aspect division is sequential;
  - `waitrequest` is honoured with held transfers;
  - changes mid-sequence restart cleanly.
- Sits between the system top-level mode/aspect logic and the VIP control slave.

Parameters:
- ADDR_W, 9, Avalon address width.
- TIMEOUT, 1000000, debounce cycles after any input change before programming starts.
- BASE_SCALER, 'h000, scaler register base.
- BASE_MIXER, 'h080, mixer register base.
- BASE_CVO, 'h100, CVO register base.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ARX  in  8  aspect numerator.
- ARY  in  8  aspect denominator.
- vmode  in  96  eight 12-bit fields, LSB first: WIDTH, HEIGHT, HFP, HS, HBP, VFP, VS, VBP.
- src_w  in  12  source active width.
- src_h  in  12  source active height.
- address  out  ADDR_W  Avalon address.
- write  out  1  Avalon write.
- writedata  out  32  Avalon write data.
- waitrequest  in  1  Avalon wait.
- busy  out  1  sequence in progress.
- done  out  1  last sequence completed with current inputs.

Behaviour:
- Reset (async assert, sync deassert handled at top):
  - address=0, write=0, writedata=0, busy=0, done=0.
  - Snapshots cleared; state=DEBOUNCE; counter=0.
- Snapshot registers hold ARX, ARY, vmode, src_w, src_h. "Change" means any snapshot differs from its live input.
- DEBOUNCE:
  - Change → reload snapshots, counter=0.
  - Otherwise counter increments; when it reaches TIMEOUT-1 → CALC_W.
  - busy=1 from the cycle counter starts after a change.
- CALC_W: restoring divider, 1 quotient bit per cycle, 24 cycles. wcalc = (HEIGHT*arx)/ary, numerator 20 bits, zero-extended to 24.
- CALC_H: same divider, 24 cycles. hcalc = (WIDTH*ary)/arx.
- Divider reset point: if arx==0 or ary==0, both division states are skipped and videow=WIDTH, videoh=HEIGHT.
- FIT (1 cycle):
  - videow = min(wcalc, WIDTH); videoh = min(hcalc, HEIGHT).
  - posx = (WIDTH-videow)>>1; posy = (HEIGHT-videoh)>>1, using 12-bit unsigned arithmetic.
- WRITE sequence, 21 entries, each with data zero-extended to 32 bits:
  - Scaler: S+3=videow, S+4=videoh, S+0=1.
  - Mixer: M+3=WIDTH, M+4=HEIGHT, M+8=posx, M+9=posy, M+'hA=1, M+0=1.
  - CVO:
    - C+4=0, C+5=0, C+6=WIDTH, C+7=HEIGHT;
    - C+9=HFP, C+'hA=HS, C+'hB=HFP+HS+HBP;
    - C+'hC=VFP, C+'hD=VS, C+'hE=VFP+VS+VBP;
    - C+'h1E=1, C+0=1.
- Handshake:
  - write=1 with stable address and writedata until the first cycle where waitrequest=0 (accept).
  - Next cycle write=0 (GAP, 1 cycle), then the next entry.
  - address and writedata are never changed while write=1.
- After the 21st accept: state=DEBOUNCE with counter saturated, busy=0, done=1.
- A change in any state:
  - Outside WRITE: immediately reload snapshots, clear done, set busy, return to DEBOUNCE.
  - During WRITE: the pending transfer completes its accept first, then the restart happens. No further entries are issued.
- Change and accept in the same cycle: the accept counts, then the restart applies.
- reset_n asserted mid-transfer: write drops asynchronously.

Optional Feature:
- Macro VIP_INTEGER_SCALE_EN.
- When defined, FIT is followed by an INT stage that reuses the divider:
  - videow = floor(videow/src_w)*src_w when src_w!=0 and videow>=src_w;
  - likewise videoh with src_h;
  - posx and posy are then recomputed.
  - Adds 48 cycles.
- When undefined: src_w and src_h are ignored except for change detection, and INT does not exist.

Test Plan:
- vmode=1280x720 (HFP110 HS40 HBP220 VFP5 VS5 VBP20), ARX=4, ARY=3, waitrequest=0, TIMEOUT=16 → 21 writes. Scaler 960/720, posx=160, posy=0, C+'hB=370, C+'hE=30; then done=1, busy=0.
- ARX=16, ARY=9 → videow=1280, videoh=720, posx=0, posy=0.
- ARX=0 → divider skipped, videow=1280, videoh=720; check the cycle count from debounce expiry to first write drops by 48.
- waitrequest held high 5 cycles on write 8 → write, address and writedata stable for 6 cycles; exactly one accept; then a 1-cycle gap.
- ARY changed 3→4 while write 10 is stalled → write 10 accepted, no write 11, debounce restarts, full 21-write sequence with new values, done only at its end.
- VIP_INTEGER_SCALE_EN defined, src 256x224, 4:3 → videow=768, videoh=672, posx=256, posy=24.
